// File: rtl/alu_test_seq.sv
// Script-driven ALU self-test sequencer: walks a ROM script, drives an internal registered ALU,
// compares results two clocks downstream, counts failures and guards runaway scripts with a watchdog.
module alu_test_seq #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MAX_STEPS = 255,
    parameter int unsigned CNT_W     = 8,
    // ROM image, entry i at [i*EW +: EW], entry = {op[3:0], arg0, arg1, cmp, xpct, next}
    parameter logic [DEPTH*(5+3*WIDTH+$clog2(DEPTH))-1:0] SCRIPT = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_run,
    output logic                     o_running,
    output logic                     o_done,
    output logic                     o_passed,
    output logic                     o_timeout,
    output logic [CNT_W-1:0]         o_fail_cnt,
    output logic [$clog2(DEPTH)-1:0] o_fail_step
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 5 + 3*WIDTH + AW;
    localparam int unsigned SW = $clog2(MAX_STEPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_PASS = 4'h6
    } op_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] arg0;
        logic [WIDTH-1:0] arg1;
        logic             cmp;
        logic [WIDTH-1:0] xpct;
        logic [AW-1:0]    next;
    } entry_t;

    state_t           state;
    logic [AW-1:0]    pc;
    logic [SW-1:0]    step;
    logic             drain_cnt;
    logic             run_q;
    logic             run_rise;
    entry_t           rom [DEPTH];
    entry_t           ent;

    op_t              alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] alu_q;

    logic             cmp_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] xpct_q;
    logic [AW-1:0]    cmp_pc;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rom[i] = SCRIPT[i*EW +: EW];
        end
    end

    assign ent      = rom[pc];
    assign run_rise = i_run & ~run_q;

    // ALU sees the active entry only while RUN; every other state feeds NO_OP
    always_comb begin
        alu_op  = OP_NOP;
        alu_a   = '0;
        alu_b   = '0;
        alu_res = '0;
        if (state == S_RUN) begin
            alu_op = op_t'(ent.op);
            alu_a  = ent.arg0;
            alu_b  = ent.arg1;
        end
        case (alu_op)
            OP_ADD:  alu_res = alu_a + alu_b;
            OP_SUB:  alu_res = alu_a - alu_b;
            OP_AND:  alu_res = alu_a & alu_b;
            OP_OR:   alu_res = alu_a | alu_b;
            OP_XOR:  alu_res = alu_a ^ alu_b;
            OP_PASS: alu_res = alu_a;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            alu_q <= '0;
        end else begin
            alu_q <= alu_res;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            pc          <= AW'(1);
            step        <= '0;
            drain_cnt   <= 1'b0;
            run_q       <= 1'b1;
            o_running   <= 1'b0;
            o_done      <= 1'b0;
            o_passed    <= 1'b1;
            o_timeout   <= 1'b0;
            o_fail_cnt  <= '0;
            o_fail_step <= '0;
            cmp_q       <= 1'b0;
            data_q      <= '0;
            xpct_q      <= '0;
            cmp_pc      <= '0;
        end else begin
            run_q <= i_run;
            cmp_q <= 1'b0;

            // retire the compare captured last cycle
            if (cmp_q && (data_q != xpct_q)) begin
                if (o_fail_cnt != '1) begin
                    o_fail_cnt <= o_fail_cnt + 1'b1;
                end
                if (o_fail_cnt == '0) begin
                    o_fail_step <= cmp_pc;
                end
                o_passed <= 1'b0;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (run_rise) begin
                        state       <= S_RUN;
                        pc          <= AW'(1);
                        step        <= '0;
                        o_running   <= 1'b1;
                        o_done      <= 1'b0;
                        o_passed    <= 1'b1;
                        o_timeout   <= 1'b0;
                        o_fail_cnt  <= '0;
                        o_fail_step <= '0;
                    end
                end
                S_RUN: begin
                    if (!i_run) begin
                        state     <= S_IDLE;
                        o_running <= 1'b0;
                    end else begin
                        cmp_q  <= ent.cmp;
                        data_q <= alu_q;
                        xpct_q <= ent.xpct;
                        cmp_pc <= pc;
                        pc     <= ent.next;
                        step   <= step + 1'b1;
                        if (ent.next == '0) begin
                            state     <= S_DRAIN;
                            drain_cnt <= 1'b0;
                        end else if (step == SW'(MAX_STEPS - 1)) begin
                            state     <= S_DRAIN;
                            drain_cnt <= 1'b0;
                            o_timeout <= 1'b1;
                            o_passed  <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!i_run) begin
                        state     <= S_IDLE;
                        o_running <= 1'b0;
                    end else if (drain_cnt) begin
                        state     <= S_DONE;
                        o_running <= 1'b0;
                        o_done    <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_test_seq.sv
// Bench for alu_test_seq: several sequencer instances with fixed and hash-generated scripts,
// $urandom-driven run timing, aborts and mid-run resets, checked against a script-walking model.
module tb_alu_test_seq;
    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a0;
        logic [15:0] a1;
        logic        c;
        logic [15:0] x;
        logic [3:0]  n;
    } ent16_t;

    logic       clk;
    logic       rst;
    logic       run     [7];
    logic       running [7];
    logic       done    [7];
    logic       passed  [7];
    logic       tmo     [7];
    logic [7:0] fcnt    [7];
    logic [3:0] fstep   [7];
    logic [1:0] fcnt_sat;
    int         ntests;
    int         nfail;

    function automatic logic [15:0] alu16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return a;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [31:0] hsh(input int unsigned i);
        logic [31:0] h;
        h = i * 32'd2654435761 + 32'd12345;
        h = h ^ (h >> 15);
        h = h * 32'd2246822519;
        h = h ^ (h >> 13);
        return h;
    endfunction

    function automatic logic [15:0] r16(input int unsigned j, input int unsigned k);
        logic [31:0] h;
        h = hsh(j * 3 + k);
        return h[15:0];
    endfunction

    function automatic logic [3:0] rop(input int unsigned j);
        return 4'(hsh(j) % 7);
    endfunction

    function automatic logic [56:0] mk16(input logic [3:0] op, input logic [15:0] a0, input logic [15:0] a1,
                                         input logic c, input logic [15:0] x, input logic [3:0] n);
        return {op, a0, a1, c, x, n};
    endfunction

    function automatic logic [56:0] entry16(input int sel, input int unsigned idx);
        logic [15:0] prev;
        logic [15:0] x;
        logic [31:0] h;
        if (idx == 0) return 57'd0;
        case (sel)
            0, 1: begin
                if (idx == 1) return mk16(4'd1, 16'd5, 16'd8, 1'b0, 16'd0, 4'd2);
                if (idx == 2) return mk16(4'd0, 16'd0, 16'd0, 1'b1, (sel == 0) ? 16'd13 : 16'd14, 4'd0);
                return 57'd0;
            end
            2: begin
                case (idx)
                    1: return mk16(4'd1, 16'd5, 16'd8, 1'b0, 16'd0, 4'd2);
                    2: return mk16(4'd3, 16'hF0F0, 16'h0FF0, 1'b1, 16'd99, 4'd3);
                    3: return mk16(4'd4, 16'd1, 16'd2, 1'b1, 16'h00F0, 4'd4);
                    4: return mk16(4'd5, 16'h00FF, 16'h000F, 1'b1, 16'd4, 4'd5);
                    5: return mk16(4'd2, 16'h0010, 16'd3, 1'b1, 16'd0, 4'd6);
                    6: return mk16(4'd0, 16'd0, 16'd0, 1'b1, 16'd13, 4'd0);
                    default: return 57'd0;
                endcase
            end
            3: begin
                case (idx)
                    1: return mk16(4'd1, 16'd2, 16'd3, 1'b0, 16'd0, 4'd2);
                    2: return mk16(4'd2, 16'd9, 16'd4, 1'b1, 16'd5, 4'd3);
                    3: return mk16(4'd1, 16'd1, 16'd1, 1'b1, 16'd7, 4'd3);
                    default: return 57'd0;
                endcase
            end
            4: begin
                prev = 16'd0;
                for (int unsigned j = 1; j < idx; j++) prev = alu16(rop(j), r16(j, 1), r16(j, 2));
                h = hsh(idx + 1000);
                x = prev;
                if (h[1:0] == 2'd0 || idx == 7) x = prev ^ (16'd1 << h[7:4]);
                return mk16(rop(idx), r16(idx, 1), r16(idx, 2), idx >= 2, x, (idx == 15) ? 4'd0 : 4'(idx + 1));
            end
            default: return 57'd0;
        endcase
    endfunction

    function automatic logic [16*57-1:0] img16(input int sel);
        logic [16*57-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) r[i*57 +: 57] = entry16(sel, i);
        return r;
    endfunction

    function automatic logic [16*105-1:0] img32();
        logic [16*105-1:0] r;
        r = '0;
        r[1*105 +: 105] = {4'd3, 32'hCCAA_CCAA, 32'hAACC_AACC, 1'b0, 32'h0, 4'd2};
        r[2*105 +: 105] = {4'd0, 32'h0, 32'h0, 1'b1, 32'h8888_8888, 4'd0};
        return r;
    endfunction

    // Walk the script as the rules describe: each compare sees the previous entry's result
    task automatic model(input int sel, input int maxs, output int fails, output int fst,
                         output int tm, output int steps, output int ffirst);
        ent16_t      e;
        logic [15:0] prev;
        int unsigned pc;
        fails = 0; fst = 0; tm = 0; steps = 0; ffirst = 0; prev = 16'd0; pc = 1;
        for (int g = 0; g < 1000; g++) begin
            e = entry16(sel, pc);
            if (e.c && prev != e.x) begin
                if (fails == 0) begin fst = int'(pc); ffirst = steps + 1; end
                fails++;
            end
            prev = alu16(e.op, e.a0, e.a1);
            steps++;
            if (e.n == 4'd0) break;
            if (steps == maxs) begin tm = 1; break; end
            pc = e.n;
        end
    endtask

    alu_test_seq #(.SCRIPT(img16(0))) u0 (.i_clk(clk), .i_rst(rst), .i_run(run[0]), .o_running(running[0]),
        .o_done(done[0]), .o_passed(passed[0]), .o_timeout(tmo[0]), .o_fail_cnt(fcnt[0]), .o_fail_step(fstep[0]));
    alu_test_seq #(.SCRIPT(img16(1))) u1 (.i_clk(clk), .i_rst(rst), .i_run(run[1]), .o_running(running[1]),
        .o_done(done[1]), .o_passed(passed[1]), .o_timeout(tmo[1]), .o_fail_cnt(fcnt[1]), .o_fail_step(fstep[1]));
    alu_test_seq #(.SCRIPT(img16(2))) u2 (.i_clk(clk), .i_rst(rst), .i_run(run[2]), .o_running(running[2]),
        .o_done(done[2]), .o_passed(passed[2]), .o_timeout(tmo[2]), .o_fail_cnt(fcnt[2]), .o_fail_step(fstep[2]));
    alu_test_seq #(.MAX_STEPS(20), .SCRIPT(img16(3))) u3 (.i_clk(clk), .i_rst(rst), .i_run(run[3]),
        .o_running(running[3]), .o_done(done[3]), .o_passed(passed[3]), .o_timeout(tmo[3]),
        .o_fail_cnt(fcnt[3]), .o_fail_step(fstep[3]));
    alu_test_seq #(.SCRIPT(img16(4))) u4 (.i_clk(clk), .i_rst(rst), .i_run(run[4]), .o_running(running[4]),
        .o_done(done[4]), .o_passed(passed[4]), .o_timeout(tmo[4]), .o_fail_cnt(fcnt[4]), .o_fail_step(fstep[4]));
    alu_test_seq #(.MAX_STEPS(20), .CNT_W(2), .SCRIPT(img16(3))) u5 (.i_clk(clk), .i_rst(rst), .i_run(run[5]),
        .o_running(running[5]), .o_done(done[5]), .o_passed(passed[5]), .o_timeout(tmo[5]),
        .o_fail_cnt(fcnt_sat), .o_fail_step(fstep[5]));
    alu_test_seq #(.WIDTH(32), .SCRIPT(img32())) u6 (.i_clk(clk), .i_rst(rst), .i_run(run[6]),
        .o_running(running[6]), .o_done(done[6]), .o_passed(passed[6]), .o_timeout(tmo[6]),
        .o_fail_cnt(fcnt[6]), .o_fail_step(fstep[6]));

    assign fcnt[5] = {6'd0, fcnt_sat};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_check(input int u, input string tag);
        int sels [6] = '{0, 1, 2, 3, 4, 3};
        int maxs [6] = '{255, 255, 255, 20, 255, 20};
        int fails, fst, tm, steps, ffirst, cnt, seen, want_cnt;
        logic got_done, run1;
        if (u == 6) begin
            fails = 0; fst = 0; tm = 0; steps = 2; ffirst = 0;
        end else begin
            model(sels[u], maxs[u], fails, fst, tm, steps, ffirst);
        end
        want_cnt = (fails > ((u == 5) ? 3 : 255)) ? ((u == 5) ? 3 : 255) : fails;
        run[u] = 1'b0;
        @(negedge clk);
        run[u] = 1'b1;
        cnt = 0; seen = 0; got_done = 1'b0; run1 = 1'b0;
        while (!got_done && cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) run1 = running[u];
            if (seen == 0 && fcnt[u] != 8'd0) seen = cnt;
            got_done = done[u];
        end
        ntests++;
        if (!got_done || cnt != steps + 3) begin
            nfail++; $display("FAIL %s done_latency: got %0d cycles (done=%0b), want %0d", tag, cnt, got_done, steps + 3);
        end
        ntests++;
        if (run1 !== 1'b1) begin nfail++; $display("FAIL %s running_at_start: got %0b, want 1", tag, run1); end
        ntests++;
        if (running[u] !== 1'b0) begin nfail++; $display("FAIL %s running_at_done: got %0b, want 0", tag, running[u]); end
        ntests++;
        if (passed[u] !== (fails == 0 && tm == 0)) begin
            nfail++; $display("FAIL %s passed: got %0b, want %0b", tag, passed[u], (fails == 0 && tm == 0));
        end
        ntests++;
        if (tmo[u] !== tm[0]) begin nfail++; $display("FAIL %s timeout: got %0b, want %0b", tag, tmo[u], tm[0]); end
        ntests++;
        if (fcnt[u] !== 8'(want_cnt)) begin nfail++; $display("FAIL %s fail_cnt: got %0d, want %0d", tag, fcnt[u], want_cnt); end
        ntests++;
        if (fstep[u] !== 4'(fst)) begin nfail++; $display("FAIL %s fail_step: got %0d, want %0d", tag, fstep[u], fst); end
        if (fails > 0) begin
            ntests++;
            if (seen != ffirst + 2) begin
                nfail++; $display("FAIL %s first_fail_time: got cycle %0d, want %0d", tag, seen, ffirst + 2);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int u = 0; u < 7; u++) begin
            ntests++;
            if ({running[u], done[u], passed[u], tmo[u], fcnt[u], fstep[u]} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'd0}) begin
                nfail++;
                $display("FAIL reset_state u%0d: got run=%0b done=%0b pass=%0b tmo=%0b cnt=%0d step=%0d, want 0 0 1 0 0 0",
                         u, running[u], done[u], passed[u], tmo[u], fcnt[u], fstep[u]);
            end
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        ntests++;
        if (running[0] !== 1'b0) begin nfail++; $display("FAIL reset_release_edge: running=%0b, want 0", running[0]); end
    endtask

    task automatic test_pass_fail();
        run_check(0, "pass");
        run_check(1, "fail_one");
        run_check(2, "fail_three");
    endtask

    task automatic test_watchdog();
        run_check(3, "watchdog");
        run_check(5, "saturate");
    endtask

    task automatic test_width32();
        run_check(6, "width32");
    endtask

    task automatic test_determinism();
        run_check(1, "repeat_fail_one");
        run_check(2, "repeat_fail_three");
        run_check(4, "random_script");
        run_check(4, "random_script_again");
    endtask

    task automatic test_abort();
        int k;
        for (int it = 0; it < 3; it++) begin
            k = int'($urandom_range(1, 12));
            run[4] = 1'b0;
            @(negedge clk);
            run[4] = 1'b1;
            repeat (k) @(negedge clk);
            run[4] = 1'b0;
            @(negedge clk);
            ntests++;
            if (running[4] !== 1'b0 || done[4] !== 1'b0) begin
                nfail++; $display("FAIL abort_after_%0d: running=%0b done=%0b, want 0 0", k, running[4], done[4]);
            end
            run_check(4, "after_abort");
        end
    endtask

    task automatic test_reset_midrun();
        run[4] = 1'b0;
        @(negedge clk);
        run[4] = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        ntests++;
        if ({running[4], done[4], passed[4], tmo[4], fcnt[4], fstep[4]} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'd0}) begin
            nfail++;
            $display("FAIL midrun_reset: got run=%0b done=%0b pass=%0b tmo=%0b cnt=%0d step=%0d, want 0 0 1 0 0 0",
                     running[4], done[4], passed[4], tmo[4], fcnt[4], fstep[4]);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        ntests++;
        if (running[4] !== 1'b0) begin nfail++; $display("FAIL restart_needs_edge: running=%0b, want 0", running[4]); end
        run_check(4, "after_midrun_reset");
    endtask

    task automatic test_back_to_back();
        int u;
        for (int it = 0; it < 5; it++) begin
            u = int'($urandom_range(0, 6));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_check(u, $sformatf("b2b_u%0d", u));
        end
    endtask

    initial begin
        ntests = 0;
        nfail  = 0;
        rst    = 1'b1;
        for (int u = 0; u < 7; u++) run[u] = 1'b0;
        run[0] = 1'b1;
        test_reset();
        test_pass_fail();
        test_watchdog();
        test_width32();
        test_determinism();
        test_abort();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
